// File: rtl/alu_issue.sv
// alu_issue: decodes an RV32I op into ALU operands and an ALU control code,
// then holds the result in a 2-entry in-order skid buffer. The ALU side is
// fed only from registers, and in_ready is computed only from buffer
// occupancy.
module alu_issue #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_rs1_val,
  input  logic [31:0]      in_rs2_val,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic [3:0]       out_alu_control,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Buffer entry layout: {a, b, alu_control, illegal, tag}
  localparam int ENT_W = 32 + 32 + 4 + 1 + TAG_W;

  // Base funct3 mapping shared by the register and immediate ALU forms;
  // the 000 and 101 slots are overridden by funct7 where SUB/SRA apply.
  function automatic logic [3:0] f3_code(input logic [2:0] f3);
    logic [3:0] code;
    case (f3)
      3'b000:  code = ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = ALU_SRL;
      3'b110:  code = ALU_OR;
      3'b111:  code = ALU_AND;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  logic [31:0]      raw_a_s;
  logic [31:0]      raw_b_s;
  logic [3:0]       raw_code_s;
  logic             ill_s;
  logic [ENT_W-1:0] dec_s;
  logic [ENT_W-1:0] slot0_r;
  logic [ENT_W-1:0] slot1_r;
  logic [1:0]       count_r;
  logic             push_s;
  logic             pop_s;

  // Decode the offered op into raw operands, control code and legality.
  always_comb begin
    raw_a_s    = 32'd0;
    raw_b_s    = 32'd0;
    raw_code_s = ALU_ADD;
    ill_s      = 1'b0;
    case (in_opcode)
      OP_R: begin
        raw_a_s = in_rs1_val;
        raw_b_s = in_rs2_val;
        if (in_funct7 == F7_BASE) begin
          raw_code_s = f3_code(in_funct3);
        end else if (in_funct7 == F7_ALT && in_funct3 == 3'b000) begin
          raw_code_s = ALU_SUB;
        end else if (in_funct7 == F7_ALT && in_funct3 == 3'b101) begin
          raw_code_s = ALU_SRA;
        end else begin
          ill_s = 1'b1;
        end
      end
      OP_I: begin
        raw_a_s = in_rs1_val;
        raw_b_s = in_imm;
        if (in_funct3 == 3'b001) begin
          if (in_funct7 == F7_BASE) begin
            raw_code_s = ALU_SLL;
          end else begin
            ill_s = 1'b1;
          end
        end else if (in_funct3 == 3'b101) begin
          if (in_funct7 == F7_BASE) begin
            raw_code_s = ALU_SRL;
          end else if (in_funct7 == F7_ALT) begin
            raw_code_s = ALU_SRA;
          end else begin
            ill_s = 1'b1;
          end
        end else begin
          // funct7 bits are immediate bits here, so ADDI etc. ignore them
          raw_code_s = f3_code(in_funct3);
        end
      end
      OP_LOAD, OP_STORE: begin
        raw_a_s = in_rs1_val;
        raw_b_s = in_imm;
      end
      OP_LUI: begin
        raw_b_s = in_imm;
      end
      OP_AUIPC: begin
        raw_a_s = in_pc;
        raw_b_s = in_imm;
      end
      OP_JAL, OP_JALR: begin
        // ALU computes the link address pc+4
        raw_a_s = in_pc;
        raw_b_s = 32'd4;
      end
      OP_BRANCH: begin
        raw_a_s = in_rs1_val;
        raw_b_s = in_rs2_val;
        case (in_funct3)
          3'b000, 3'b001: raw_code_s = ALU_SUB;
          3'b100, 3'b101: raw_code_s = ALU_SLT;
          3'b110, 3'b111: raw_code_s = ALU_SLTU;
          default:        ill_s      = 1'b1;
        endcase
      end
      default: begin
        ill_s = 1'b1;
      end
    endcase
  end

  // Illegal ops travel as a zeroed ADD so that downstream sees harmless operands.
  always_comb begin
    if (ill_s) begin
      dec_s = {32'd0, 32'd0, ALU_ADD, 1'b1, in_tag};
    end else begin
      dec_s = {raw_a_s, raw_b_s, raw_code_s, 1'b0, in_tag};
    end
  end

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign push_s    = in_valid & in_ready & ~flush;
  assign pop_s     = out_valid & out_ready;

  assign {out_a, out_b, out_alu_control, out_illegal, out_tag} = slot0_r;

  // Skid-buffer state: slot0 is always the head, slot1 the second-oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 2'd0;
      slot0_r <= {ENT_W{1'b0}};
      slot1_r <= {ENT_W{1'b0}};
    end else if (flush) begin
      count_r <= 2'd0;
    end else begin
      case (count_r)
        2'd0: begin
          if (push_s) begin
            slot0_r <= dec_s;
            count_r <= 2'd1;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            slot0_r <= dec_s;
          end else if (push_s) begin
            slot1_r <= dec_s;
            count_r <= 2'd2;
          end else if (pop_s) begin
            count_r <= 2'd0;
          end
        end
        2'd2: begin
          if (pop_s) begin
            slot0_r <= slot1_r;
            count_r <= 2'd1;
          end
        end
        default: begin
          count_r <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: table-driven decode vectors streamed through alu_issue, with
// a queue scoreboard that tracks which ops should be buffered and checks the
// head every cycle, plus short hand-written sequences for backpressure,
// flush and reset taken mid-stream.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_pc, out_a, out_b;
  logic [4:0]  in_tag, out_tag;
  logic [3:0]  out_alu_control;

  alu_issue #(.TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_control(out_alu_control),
    .out_illegal(out_illegal), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1, rs2, imm, pc;
    logic [31:0] ea, eb;
    logic [3:0]  ec;
    logic        eill;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic        ill;
    logic [4:0]  tag;
  } exp_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  exp_t q [$];
  exp_t exp_cur;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                              input logic [31:0] pc, input logic [31:0] ea, input logic [31:0] eb,
                              input logic [3:0] ec, input logic eill);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
    v.ea = ea; v.eb = eb; v.ec = ec; v.eill = eill;
    return v;
  endfunction

  // Present vector i with the given tag and record what it must decode to.
  task automatic drive(input int i, input logic [4:0] tag);
    in_valid   = 1'b1;
    in_opcode  = vecs[i].op;
    in_funct3  = vecs[i].f3;
    in_funct7  = vecs[i].f7;
    in_rs1_val = vecs[i].rs1;
    in_rs2_val = vecs[i].rs2;
    in_imm     = vecs[i].imm;
    in_pc      = vecs[i].pc;
    in_tag     = tag;
    exp_cur    = '{a: vecs[i].ea, b: vecs[i].eb, c: vecs[i].ec, ill: vecs[i].eill, tag: tag};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: check handshake flags and head against the model, then apply this cycle's pop/flush/push.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      chk("in_ready", {79'd0, in_ready}, {79'd0, (q.size() != 2)});
      chk("out_valid", {79'd0, out_valid}, {79'd0, (q.size() != 0)});
      if (q.size() != 0) begin
        chk("head_a", {48'd0, out_a}, {48'd0, q[0].a});
        chk("head_b", {48'd0, out_b}, {48'd0, q[0].b});
        chk("head_ctrl_ill_tag", {70'd0, out_alu_control, out_illegal, out_tag},
            {70'd0, q[0].c, q[0].ill, q[0].tag});
      end
      if (out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && in_ready && q.size() < 2) begin
        q.push_back(exp_cur);
      end
    end
  end

  initial begin
    //               op          f3      f7          rs1           rs2           imm           pc            exp a         exp b         code     ill
    vecs[0]  = mk(7'b0110011, 3'b000, 7'b0100000, 32'd10,       32'd3,        32'd0,        32'd0,        32'd10,       32'd3,        4'b0001, 1'b0);
    vecs[1]  = mk(7'b0110011, 3'b000, 7'b0000000, 32'd5,        32'd6,        32'd9,        32'd0,        32'd5,        32'd6,        4'b0000, 1'b0);
    vecs[2]  = mk(7'b0110011, 3'b111, 7'b0000000, 32'hF0F0,     32'h0FF0,     32'd0,        32'd0,        32'hF0F0,     32'h0FF0,     4'b0010, 1'b0);
    vecs[3]  = mk(7'b0110011, 3'b001, 7'b0100000, 32'd1,        32'd2,        32'd0,        32'd0,        32'd0,        32'd0,        4'b0000, 1'b1);
    vecs[4]  = mk(7'b0110011, 3'b101, 7'b0100000, 32'h8000_0000,32'd4,        32'd0,        32'd0,        32'h8000_0000,32'd4,        4'b1001, 1'b0);
    vecs[5]  = mk(7'b0010011, 3'b101, 7'b0100000, 32'h8000_0000,32'd7,        32'h404,      32'd0,        32'h8000_0000,32'h404,      4'b1001, 1'b0);
    vecs[6]  = mk(7'b0010011, 3'b101, 7'b0000001, 32'h8000_0000,32'd7,        32'h404,      32'd0,        32'd0,        32'd0,        4'b0000, 1'b1);
    vecs[7]  = mk(7'b0010011, 3'b000, 7'b0100000, 32'd100,      32'd7,        32'hFFFF_FC00,32'd0,        32'd100,      32'hFFFF_FC00,4'b0000, 1'b0);
    vecs[8]  = mk(7'b0010011, 3'b011, 7'b0000000, 32'd3,        32'd7,        32'd12,       32'd0,        32'd3,        32'd12,       4'b0110, 1'b0);
    vecs[9]  = mk(7'b0010111, 3'b000, 7'b0000000, 32'd11,       32'd12,       32'h2000,     32'h1000,     32'h1000,     32'h2000,     4'b0000, 1'b0);
    vecs[10] = mk(7'b1101111, 3'b000, 7'b0000000, 32'd11,       32'd12,       32'd88,       32'h40,       32'h40,       32'd4,        4'b0000, 1'b0);
    vecs[11] = mk(7'b0110111, 3'b000, 7'b0000000, 32'd11,       32'd12,       32'h1234_5000,32'h80,       32'd0,        32'h1234_5000,4'b0000, 1'b0);
    vecs[12] = mk(7'b1100011, 3'b110, 7'b0000000, 32'd21,       32'd22,       32'd8,        32'd0,        32'd21,       32'd22,       4'b0110, 1'b0);
    vecs[13] = mk(7'b1100011, 3'b010, 7'b0000000, 32'd21,       32'd22,       32'd8,        32'd0,        32'd0,        32'd0,        4'b0000, 1'b1);
    vecs[14] = mk(7'b0100011, 3'b010, 7'b0000000, 32'h300,      32'd5,        32'd16,       32'd0,        32'h300,      32'd16,       4'b0000, 1'b0);
    vecs[15] = mk(7'b1111111, 3'b000, 7'b0000000, 32'd1,        32'd2,        32'd3,        32'd4,        32'd0,        32'd0,        4'b0000, 1'b1);
    vecs[16] = mk(7'b0110011, 3'b110, 7'b0000000, 32'd9,        32'd6,        32'd0,        32'd0,        32'd9,        32'd6,        4'b0011, 1'b0);
    vecs[17] = mk(7'b0110011, 3'b100, 7'b0000000, 32'd9,        32'd6,        32'd0,        32'd0,        32'd9,        32'd6,        4'b0100, 1'b0);
    vecs[18] = mk(7'b0010011, 3'b010, 7'b0000000, 32'd9,        32'd6,        32'hFFFF_FFFF,32'd0,        32'd9,        32'hFFFF_FFFF,4'b0101, 1'b0);
    vecs[19] = mk(7'b0010011, 3'b101, 7'b0000000, 32'd9,        32'd6,        32'd3,        32'd0,        32'd9,        32'd3,        4'b1000, 1'b0);
    vecs[20] = mk(7'b1100011, 3'b101, 7'b0000000, 32'd7,        32'd8,        32'd0,        32'd0,        32'd7,        32'd8,        4'b0101, 1'b0);

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(0, 5'd0);
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    // Reset state
    chk("rst_out_valid", {79'd0, out_valid}, 80'd0);
    chk("rst_in_ready", {79'd0, in_ready}, 80'd1);
    chk("rst_out_a", {48'd0, out_a}, 80'd0);
    chk("rst_out_b", {48'd0, out_b}, 80'd0);
    chk("rst_ctrl_ill_tag", {70'd0, out_alu_control, out_illegal, out_tag}, 80'd0);

    // First op into an empty buffer: REQ-023 SUB, tag 7, visible one cycle later
    drive(0, 5'd7);
    tick();
    in_valid = 1'b0;
    chk("sub_latency_valid", {79'd0, out_valid}, 80'd1);
    chk("sub_code", {76'd0, out_alu_control}, 80'd1);
    chk("sub_tag", {75'd0, out_tag}, 80'd7);
    out_ready = 1'b1;
    tick();

    // Streaming every vector back to back with the ALU always ready
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(i, 5'(i + 1));
      tick();
      chk("stream_in_ready", {79'd0, in_ready}, 80'd1);
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("stream_drained", {79'd0, out_valid}, 80'd0);

    // Backpressure: three ops offered, only two fit
    out_ready = 1'b0;
    drive(1, 5'd20); tick();
    drive(2, 5'd21); tick();
    chk("bp_full_in_ready", {79'd0, in_ready}, 80'd0);
    drive(4, 5'd22); tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_before_pop_in_ready", {79'd0, in_ready}, 80'd0);
    chk("bp_head_tag", {75'd0, out_tag}, 80'd20);
    tick();
    chk("bp_after_pop_in_ready", {79'd0, in_ready}, 80'd1);
    chk("bp_second_tag", {75'd0, out_tag}, 80'd21);
    tick();
    chk("bp_empty", {79'd0, out_valid}, 80'd0);

    // Flush with two buffered ops and a third on offer
    out_ready = 1'b0;
    drive(5, 5'd23); tick();
    drive(6, 5'd24); tick();
    drive(9, 5'd25); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {79'd0, out_valid}, 80'd0);
    chk("flush_in_ready", {79'd0, in_ready}, 80'd1);
    out_ready = 1'b1;
    tick(); tick();

    // Reset in mid-stream with an op on offer
    out_ready = 1'b0;
    drive(10, 5'd26); tick();
    drive(11, 5'd27); tick();
    drive(12, 5'd28); rst = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_out_valid", {79'd0, out_valid}, 80'd0);
    chk("midrst_in_ready", {79'd0, in_ready}, 80'd1);
    chk("midrst_out_a", {48'd0, out_a}, 80'd0);
    chk("midrst_out_b", {48'd0, out_b}, 80'd0);
    chk("midrst_ctrl_ill_tag", {70'd0, out_alu_control, out_illegal, out_tag}, 80'd0);
    tick(); tick();
    chk("final_queue_empty", {48'd0, 32'(q.size())}, 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
